hacd_axi_rd_sched: RTL and testbench

HACD_AXI_RD_SCHED -- requirements
Module: hacd_axi_rd_sched

---
 rtl/hacd_axi_rd_sched_pkg.sv | 25 ++
 rtl/hacd_axi_rd_sched_if.sv | 34 +++
 rtl/hacd_axi_rd_sched_rr_arbiter.sv | 42 ++++
 rtl/hacd_axi_rd_sched.sv | 154 +++++++++++++++
 tb/tb_hacd_axi_rd_sched.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hacd_axi_rd_sched_pkg.sv
// Shared hacd AXI4 defaults, burst/size encodings and read-scheduler FSM states.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 32
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif

package hacd_axi_rd_sched_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } rd_state_e;

  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/hacd_axi_rd_sched_if.sv
// AXI4 read-address and read-data channels between the scheduler and a crossbar port.
interface hacd_axi_rd_sched_if #(
  parameter int unsigned ID_WIDTH   = `HACD_AXI4_ID_WIDTH,
  parameter int unsigned ADDR_WIDTH = `HACD_AXI4_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `HACD_AXI4_DATA_WIDTH
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/hacd_axi_rd_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last acknowledged one.
module hacd_rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  input  logic [N-1:0] ack_gnt,
  output logic [N-1:0] gnt
);
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] last_q;
  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = W'((32'(last_q) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Pointer follows the acknowledged grant, not the live one, so requests that
  // change while a grant is pending cannot skew the rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= W'(N - 1);
    end else if (ack) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (ack_gnt[i]) last_q <= W'(i);
      end
    end
  end
endmodule

// File: rtl/hacd_axi_rd_sched.sv
// Multi-requester AXI4 read scheduler: round-robin AR issue, ID-based R routing, outstanding tracking.
module hacd_axi_rd_sched
  import hacd_axi_rd_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = `HACD_AXI4_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `HACD_AXI4_DATA_WIDTH,
  parameter int unsigned ID_WIDTH   = `HACD_AXI4_ID_WIDTH,
  parameter int unsigned MAX_OUT    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*8-1:0]          req_len,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic [N_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_last,
  hacd_axi_rd_sched_if.master         m_axi,
  output logic                        err_bad_id,
  output logic [N_REQ*4-1:0]          outstanding
);
  localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [2:0]  AR_SIZE = axi_size(DATA_WIDTH);
  localparam logic [3:0]  MAX_CNT = 4'(MAX_OUT);

  rd_state_e             state_q, state_d;
  logic [N_REQ-1:0]      elig, gnt, gnt_q, dec;
  logic [3:0]            cnt [N_REQ];
  logic [ID_WIDTH-1:0]   gnt_id, ar_id;
  logic [ADDR_WIDTH-1:0] gnt_addr, ar_addr;
  logic [7:0]            gnt_len, ar_len;
  logic                  ar_hs, r_hs, bad_id, underflow;
  logic [IDX_W-1:0]      sel;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt[i] < MAX_CNT);
    end
  end

  hacd_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (elig),
    .ack     (ar_hs),
    .ack_gnt (gnt_q),
    .gnt     (gnt)
  );

  always_comb begin
    gnt_id   = '0;
    gnt_addr = '0;
    gnt_len  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_id   = ID_WIDTH'(i);
        gnt_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_len  = req_len[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && |elig) begin
          state_d   = ST_ISSUE;
          req_ready = gnt;
        end
      end
      ST_ISSUE: begin
        if (ar_hs) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      ar_id   <= '0;
      ar_addr <= '0;
      ar_len  <= '0;
    end else if (state_q == ST_IDLE && |elig) begin
      gnt_q   <= gnt;
      ar_id   <= gnt_id;
      ar_addr <= gnt_addr;
      ar_len  <= gnt_len;
    end
  end

  assign ar_hs          = m_axi.arvalid && m_axi.arready;
  assign m_axi.arvalid  = (state_q == ST_ISSUE);
  assign m_axi.arid     = ar_id;
  assign m_axi.araddr   = ar_addr;
  assign m_axi.arlen    = ar_len;
  assign m_axi.arsize   = AR_SIZE;
  assign m_axi.arburst  = AXI_BURST_INCR;

  // arid is a zero-extended index, so any set bit above the index range also
  // marks the beat as foreign.
  assign sel    = m_axi.rid[IDX_W-1:0];
  assign bad_id = (m_axi.rid >= ID_WIDTH'(N_REQ));

  always_comb begin
    rsp_valid    = '0;
    m_axi.rready = 1'b1;
    underflow    = 1'b0;
    dec          = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!bad_id && sel == IDX_W'(i)) begin
        rsp_valid[i] = m_axi.rvalid;
        m_axi.rready = rsp_ready[i];
        underflow    = (cnt[i] == '0);
        dec[i]       = m_axi.rvalid && rsp_ready[i] && m_axi.rlast && (cnt[i] != '0);
      end
    end
  end

  assign r_hs     = m_axi.rvalid && m_axi.rready;
  assign rsp_data = m_axi.rdata;
  assign rsp_resp = m_axi.rresp;
  assign rsp_last = m_axi.rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_bad_id <= 1'b0;
    else if (r_hs && (bad_id || underflow)) err_bad_id <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && !dec[i])      cnt[i] <= cnt[i] + 4'd1;
        else if (dec[i] && !req_ready[i]) cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) outstanding[i*4 +: 4] = cnt[i];
  end
endmodule

// File: tb/tb_hacd_axi_rd_sched.sv
// Bench for hacd_axi_rd_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_hacd_axi_rd_sched;
  localparam int N = 2, AW = 32, DW = 32, IW = 4, MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_resp;
  logic            rsp_last, err_bad_id;
  logic [N*4-1:0]  outstanding;

  hacd_axi_rd_sched_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  hacd_axi_rd_sched #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_last(rsp_last), .m_axi(axi), .err_bad_id(err_bad_id), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int len; } burst_t;

  int errors = 0, checks = 0, cyc = 0;
  // model state
  int m_cnt [N];
  int m_last, m_pid;
  bit m_pend, m_err;
  logic [AW-1:0] m_paddr;
  logic [7:0]    m_plen;
  // logs and R-slave state
  int dut_ar_id[$], dut_ar_cyc[$], mdl_ar_id[$];
  logic [DW-1:0] dlv_data[$];
  burst_t bq[$];
  bit last_r_hs, s_active, s_presented;
  int s_id, s_len, s_beat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_last = N - 1; m_pend = 0; m_err = 0; m_pid = 0;
    bq.delete(); s_active = 0; s_presented = 0; last_r_hs = 0;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0;
    axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
  endtask

  // One clock: check DUT against the model at the falling edge, advance the model, return after the rising edge.
  task automatic step();
    logic [N-1:0] exp_rr, exp_rv;
    logic [N*4-1:0] exp_out;
    logic exp_rready;
    int g, c, rid;
    bit bad, r_hs, ar_hs;
    burst_t b;
    @(negedge clk);
    cyc++;
    last_r_hs = 0;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_arvalid", axi.arvalid, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err_bad_id, 0);
      model_reset();
    end else begin
      g = -1;
      if (!m_pend) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (g < 0 && req_valid[c] && m_cnt[c] < MAX_OUT) g = c;
        end
      end
      exp_rr = '0;
      if (g >= 0) exp_rr[g] = 1'b1;
      chk("req_ready", req_ready, exp_rr);
      chk("arvalid", axi.arvalid, m_pend);
      if (m_pend) begin
        chk("arid", axi.arid, m_pid);
        chk("araddr", axi.araddr, m_paddr);
        chk("arlen", axi.arlen, m_plen);
        chk("arsize", axi.arsize, 2);
        chk("arburst", axi.arburst, 1);
      end
      rid = int'(axi.rid);
      bad = (rid >= N);
      if (bad) exp_rready = 1'b1;
      else     exp_rready = rsp_ready[rid];
      exp_rv = '0;
      if (!bad && axi.rvalid) exp_rv[rid] = 1'b1;
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rready", axi.rready, exp_rready);
      if (axi.rvalid && !bad) begin
        chk("rsp_data", rsp_data, axi.rdata);
        chk("rsp_resp", rsp_resp, axi.rresp);
        chk("rsp_last", rsp_last, axi.rlast);
      end
      for (int i = 0; i < N; i++) exp_out[i*4 +: 4] = 4'(m_cnt[i]);
      chk("outstanding", outstanding, exp_out);
      chk("err_bad_id", err_bad_id, m_err);
      if (axi.arvalid && axi.arready) begin
        dut_ar_id.push_back(int'(axi.arid));
        dut_ar_cyc.push_back(cyc);
      end
      if (rsp_valid[1] && rsp_ready[1]) dlv_data.push_back(rsp_data);
      r_hs  = axi.rvalid && exp_rready;
      ar_hs = m_pend && axi.arready;
      last_r_hs = r_hs;
      if (r_hs) begin
        if (bad || m_cnt[rid] == 0) m_err = 1;
        else if (axi.rlast)         m_cnt[rid]--;
      end
      if (g >= 0) m_cnt[g]++;
      if (ar_hs) begin
        m_pend = 0; m_last = m_pid;
        mdl_ar_id.push_back(m_pid);
        b.id = m_pid; b.len = int'(m_plen);
        bq.push_back(b);
      end
      if (g >= 0) begin
        m_pend = 1; m_pid = g;
        m_paddr = req_addr[g*AW +: AW];
        m_plen  = req_len[g*8 +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    dut_ar_id.delete(); dut_ar_cyc.delete(); mdl_ar_id.delete(); dlv_data.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat;
    bit tog;
    burst_t b;
    idle_inputs();
    model_reset();

    // Both requesters always valid: alternating ids, one AR every two cycles.
    do_reset();
    req_valid = 2'b11; req_addr = {32'h0000_1100, 32'h0000_1000}; axi.arready = 1'b1;
    for (int n = 0; n < 10; n++) step();
    chk("t1_ar_count", dut_ar_id.size(), 5);
    if (dut_ar_id.size() >= 4 && mdl_ar_id.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t1_arid", dut_ar_id[k], k % 2);
        chk("t1_model_arid", mdl_ar_id[k], k % 2);
        if (k > 0) chk("t1_spacing", dut_ar_cyc[k] - dut_ar_cyc[k-1], 2);
      end
    end

    // Requester 0 saturates at MAX_OUT; requester 1 still served.
    do_reset();
    req_valid = 2'b01; req_addr = {32'h0000_2100, 32'h0000_2000}; axi.arready = 1'b1;
    for (int n = 0; n < 10; n++) step();
    chk("t2_out0_full", outstanding, 8'h04);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) step();
    chk("t2_r1_served", outstanding, 8'h24);

    // AR stall: fields held for 5 cycles, handshake on the 6th.
    do_reset();
    req_valid = 2'b01; req_addr[31:0] = 32'hA5A5_0040; req_len[7:0] = 8'd5; axi.arready = 1'b0;
    step();
    req_valid = 2'b00; req_addr = '1; req_len = '1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t3_arvalid", axi.arvalid, 1);
      chk("t3_araddr", axi.araddr, 32'hA5A5_0040);
      chk("t3_arlen", axi.arlen, 5);
      chk("t3_arid", axi.arid, 0);
    end
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
    chk("t3_back_idle", axi.arvalid, 0);

    // Four-beat burst to requester 1 with toggling rsp_ready.
    do_reset();
    req_valid = 2'b10; req_addr[63:32] = 32'h0000_2000; req_len[15:8] = 8'd3; axi.arready = 1'b1;
    step(); step();
    req_valid = 2'b00; axi.arready = 1'b0;
    chk("t4_out_issued", outstanding, 8'h10);
    beat = 0; tog = 1'b0;
    for (int t = 0; t < 40 && beat < 4; t++) begin
      axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata = 32'hD000_0000 + beat;
      axi.rlast = (beat == 3); rsp_ready = {tog, 1'b1}; tog = ~tog;
      if (beat == 3) chk("t4_out_before_last", outstanding, 8'h10);
      step();
      if (last_r_hs) beat++;
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    chk("t4_beats", beat, 4);
    chk("t4_out_after", outstanding, 8'h00);
    chk("t4_dlv_count", dlv_data.size(), 4);
    for (int k = 0; k < dlv_data.size() && k < 4; k++) chk("t4_order", dlv_data[k], 32'hD000_0000 + k);

    // Grant and rlast for requester 0 in the same cycle.
    do_reset();
    req_valid = 2'b01; req_addr[31:0] = 32'h0000_3000; req_len[7:0] = 8'd0; axi.arready = 1'b1;
    step(); step();
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rlast = 1'b1; rsp_ready = 2'b01;
    step();
    axi.rvalid = 1'b0; req_valid = 2'b00;
    chk("t5_same_cycle", outstanding[3:0], 1);

    // Foreign id: consumed, sticky error, cleared by reset.
    do_reset();
    axi.rvalid = 1'b1; axi.rid = 4'd3; axi.rlast = 1'b1; rsp_ready = 2'b00;
    step();
    axi.rvalid = 1'b0;
    chk("t6_err_set", err_bad_id, 1);
    for (int n = 0; n < 3; n++) step();
    chk("t6_err_sticky", err_bad_id, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_err_cleared", err_bad_id, 0);
    step();

    // Beat for an idle requester must not underflow.
    do_reset();
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rlast = 1'b1; rsp_ready = 2'b01;
    step();
    axi.rvalid = 1'b0;
    chk("t7_underflow_err", err_bad_id, 1);
    chk("t7_no_underflow", outstanding, 8'h00);

    // Random traffic with an in-order R slave and occasional mid-flight resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      req_valid = 2'($urandom);
      req_addr  = {$urandom, $urandom};
      req_len   = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      axi.arready = ($urandom_range(0, 2) != 0);
      rsp_ready = 2'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0; axi.rvalid = 1'b0;
        s_active = 0; s_presented = 0; bq.delete();
      end else begin
        rst_n = 1'b1;
        if (last_r_hs) begin
          s_presented = 0;
          if (s_beat == s_len) s_active = 0;
          else                 s_beat++;
        end
        if (!s_active && bq.size() > 0) begin
          b = bq.pop_front();
          s_id = b.id; s_len = b.len; s_beat = 0; s_active = 1;
        end
        if (!s_presented) begin
          axi.rvalid = 1'b0;
          if (s_active && $urandom_range(0, 3) != 0) begin
            axi.rvalid = 1'b1; axi.rid = IW'(s_id); axi.rdata = $urandom;
            axi.rresp = 2'($urandom); axi.rlast = (s_beat == s_len); s_presented = 1;
          end
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
